// File: rtl/alu_top.sv
// 6-bit registered MIPS-style ALU built from ripple-connected 1-bit slices.
// aluOp[3] inverts A, aluOp[2] inverts B, aluOp[1:0] selects AND/OR/ADD/SLT.
// All outputs are registered; latency is one clock.

module alu_slice (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_ainv,
  input  logic       i_binv,
  input  logic       i_cin,
  input  logic       i_less,
  input  logic [1:0] i_op,
  output logic       o_res,
  output logic       o_sum,
  output logic       o_cout
);

  logic w_a;
  logic w_b;
  logic w_and;
  logic w_or;

  assign w_a    = i_ainv ? ~i_a : i_a;
  assign w_b    = i_binv ? ~i_b : i_b;
  assign w_and  = w_a & w_b;
  assign w_or   = w_a | w_b;
  assign o_sum  = w_a ^ w_b ^ i_cin;
  assign o_cout = (w_a & w_b) | (i_cin & (w_a ^ w_b));

  // Per-bit result select; SLT bits take the externally supplied less input
  always_comb begin
    o_res = 1'b0;
    unique case (i_op)
      2'b00:   o_res = w_and;
      2'b01:   o_res = w_or;
      2'b10:   o_res = o_sum;
      default: o_res = i_less;
    endcase
  end

endmodule

module alu_top #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  input  logic [3:0]       aluOp,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] w_result;
  logic             w_set;
  logic             w_cin_msb;
  logic             w_cout_msb;
  logic             w_sum_msb;
  logic             w_ovf_raw;
  logic             w_arith;
  logic             w_carry_nxt;
  logic             w_ovf_nxt;
  logic             w_zero_nxt;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_ovf;

  // Each slice owns its carry nets so the ripple chain is a set of distinct
  // signals rather than one self-dependent vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    logic w_cin;
    logic w_cout;
    logic w_sum;
    logic w_less;

    if (i == 0) begin : g_lsb
      assign w_cin  = carryIn;
      assign w_less = w_set;
    end else begin : g_upper
      assign w_cin  = g_slice[i-1].w_cout;
      assign w_less = 1'b0;
    end

    alu_slice u_slice (
      .i_a    (a[i]),
      .i_b    (b[i]),
      .i_ainv (aluOp[3]),
      .i_binv (aluOp[2]),
      .i_cin  (w_cin),
      .i_less (w_less),
      .i_op   (aluOp[1:0]),
      .o_res  (w_result[i]),
      .o_sum  (w_sum),
      .o_cout (w_cout)
    );
  end

  assign w_cin_msb   = g_slice[WIDTH-1].w_cin;
  assign w_cout_msb  = g_slice[WIDTH-1].w_cout;
  assign w_sum_msb   = g_slice[WIDTH-1].w_sum;
  assign w_ovf_raw   = w_cin_msb ^ w_cout_msb;
  assign w_set       = w_sum_msb ^ w_ovf_raw;
  assign w_arith     = aluOp[1];
  assign w_carry_nxt = w_arith & w_cout_msb;
  assign w_ovf_nxt   = w_arith & w_ovf_raw;
  assign w_zero_nxt  = ~|w_result;

  // Output register stage with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_result <= w_result;
      r_carry  <= w_carry_nxt;
      r_zero   <= w_zero_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  assign result   = r_result;
  assign carryOut = r_carry;
  assign zero     = r_zero;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_alu_top.sv
// Directed-vector bench for alu_top; expected values are hand-computed.
// Each comparison packs {result, carryOut, zero, overflow} into one 9-bit word.

module tb_alu_top;

  logic       clk;
  logic       rst;
  logic [5:0] a;
  logic [5:0] b;
  logic       carryIn;
  logic [3:0] aluOp;
  logic [5:0] result;
  logic       carryOut;
  logic       zero;
  logic       overflow;

  int n_pass;
  int n_total;

  alu_top #(.WIDTH(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .carryIn  (carryIn),
    .aluOp    (aluOp),
    .result   (result),
    .carryOut (carryOut),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, clock it, and leave time just after the edge
  task automatic drive(input logic r, input logic [5:0] va, input logic [5:0] vb,
                       input logic ci, input logic [3:0] op);
    rst = r; a = va; b = vb; carryIn = ci; aluOp = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    logic [8:0] got;
    drive(1'b1, 6'b101010, 6'b010101, 1'b1, 4'b0010);
    drive(1'b1, 6'b111111, 6'b000001, 1'b0, 4'b0010);
    exp = {6'b000000, 1'b0, 1'b1, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL reset: got %b required %b", got, exp);
    else n_pass++;
    drive(1'b0, 6'b001000, 6'b001111, 1'b0, 4'b0000);
    exp = {6'b001000, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL and_after_reset: got %b required %b", got, exp);
    else n_pass++;
  endtask

  task automatic test_logic();
    logic [8:0] exp;
    logic [8:0] got;
    drive(1'b0, 6'b001000, 6'b001111, 1'b0, 4'b0001);
    exp = {6'b001111, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL or: got %b required %b", got, exp);
    else n_pass++;
    drive(1'b0, 6'b001000, 6'b001111, 1'b0, 4'b1100);
    exp = {6'b110000, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL nor: got %b required %b", got, exp);
    else n_pass++;
    // ~a & b: 110111 & 001111
    drive(1'b0, 6'b001000, 6'b001111, 1'b0, 4'b1000);
    exp = {6'b000111, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL nota_and_b: got %b required %b", got, exp);
    else n_pass++;
    // AND with carryIn=1 and a carry-producing operand pair: carryOut stays 0
    drive(1'b0, 6'b111111, 6'b111111, 1'b1, 4'b0000);
    exp = {6'b111111, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL and_no_carry: got %b required %b", got, exp);
    else n_pass++;
  endtask

  task automatic test_add();
    logic [8:0] exp;
    logic [8:0] got;
    drive(1'b0, 6'b001000, 6'b001111, 1'b0, 4'b0010);
    exp = {6'b010111, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL add: got %b required %b", got, exp);
    else n_pass++;
    drive(1'b0, 6'b011111, 6'b000001, 1'b0, 4'b0010);
    exp = {6'b100000, 1'b0, 1'b0, 1'b1};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL add_overflow: got %b required %b", got, exp);
    else n_pass++;
    drive(1'b0, 6'b111111, 6'b000001, 1'b0, 4'b0010);
    exp = {6'b000000, 1'b1, 1'b1, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL add_wrap: got %b required %b", got, exp);
    else n_pass++;
    // carryIn honoured on ADD: 8 + 15 + 1 = 24
    drive(1'b0, 6'b001000, 6'b001111, 1'b1, 4'b0010);
    exp = {6'b011000, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL add_cin: got %b required %b", got, exp);
    else n_pass++;
  endtask

  task automatic test_sub_slt();
    logic [8:0] exp;
    logic [8:0] got;
    drive(1'b0, 6'b001000, 6'b001111, 1'b1, 4'b0110);
    exp = {6'b111001, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL sub: got %b required %b", got, exp);
    else n_pass++;
    drive(1'b0, 6'b001000, 6'b001111, 1'b1, 4'b0111);
    exp = {6'b000001, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL slt_true: got %b required %b", got, exp);
    else n_pass++;
    // 15 - 8: sum 000111 with carry out, set=0
    drive(1'b0, 6'b001111, 6'b001000, 1'b1, 4'b0111);
    exp = {6'b000000, 1'b1, 1'b1, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL slt_false: got %b required %b", got, exp);
    else n_pass++;
    // 011111 - 100000 overflows (31 - (-32)); set = msb(1) ^ ovf(1) = 0
    drive(1'b0, 6'b011111, 6'b100000, 1'b1, 4'b0111);
    exp = {6'b000000, 1'b0, 1'b1, 1'b1};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL slt_overflow: got %b required %b", got, exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    logic [8:0] got;
    drive(1'b0, 6'b001000, 6'b001111, 1'b0, 4'b0010);
    exp = {6'b010111, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL b2b_add: got %b required %b", got, exp);
    else n_pass++;
    // Inputs changed between edges must not reach the outputs
    a = 6'b111111; b = 6'b111111; aluOp = 4'b0001;
    #3;
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL b2b_hold: got %b required %b", got, exp);
    else n_pass++;
    drive(1'b0, 6'b001000, 6'b001111, 1'b0, 4'b0001);
    exp = {6'b001111, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL b2b_or: got %b required %b", got, exp);
    else n_pass++;
    drive(1'b1, 6'b001000, 6'b001111, 1'b1, 4'b0110);
    exp = {6'b000000, 1'b0, 1'b1, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL b2b_reset: got %b required %b", got, exp);
    else n_pass++;
    drive(1'b0, 6'b001000, 6'b001111, 1'b1, 4'b0110);
    exp = {6'b111001, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL b2b_sub: got %b required %b", got, exp);
    else n_pass++;
    drive(1'b0, 6'b001000, 6'b001111, 1'b0, 4'b1100);
    exp = {6'b110000, 1'b0, 1'b0, 1'b0};
    got = {result, carryOut, zero, overflow};
    n_total++;
    if (got !== exp) $display("FAIL b2b_nor: got %b required %b", got, exp);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1; a = '0; b = '0; carryIn = 1'b0; aluOp = '0;
    test_reset();
    test_logic();
    test_add();
    test_sub_slt();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
